bounded_mem_1r1w: RTL and testbench
===================================

Name: bounded_mem_1r1w

Overview:
- Parametrised successor of the team's single-threshold predicate memory. It is a 1-write/1-read memory that only stores words strictly below a threshold.
- Memory is cleared by a post-reset init sweep, so the invariant "every stored word < THRESH" holds from the first ready cycle.
- Read port is registered, with a valid pulse. Rejected writes are counted.
- Embedded formal assertions serve as the model-checking target for our sample/regression suite.

Parameters:
- W, 32, data width in bits
- AW, 8, address width; DEPTH = 2**AW words
- THRESH, 200, exclusive upper bound on stored values; legal range 1..2**W-1 (checked at elaboration)
- CW, 16, reject counter width
- WR_FIRST, 0, 0 = read-first on same-address collision, 1 = write-first (bypass)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- wr_data  in  W  write data
- rd_en  in  1  read request
- rd_addr  in  AW  read address
- rd_data  out  W  registered read data
- rd_valid  out  1  one-cycle pulse, rd_data valid
- ready  out  1  high once init sweep is done
- reject_cnt  out  CW  saturating count of rejected writes

Behaviour:
- Reset (async assert, sync release): state=INIT, sweep ptr=0, ready=0, rd_valid=0, rd_data=0, reject_cnt=0. Memory contents are not reset directly.
- INIT: each cycle writes 0 to mem[ptr] and increments ptr. After writing DEPTH-1 (exactly DEPTH cycles after reset release), go to RUN; ready=1 from the next cycle.
- INIT: wr_en/rd_en are ignored (no write, no rd_valid, no count).
- RUN accept: wr_en && wr_data < THRESH writes mem[wr_addr] at the clock edge.
- RUN reject: wr_en && wr_data >= THRESH leaves memory unchanged. reject_cnt += 1, saturating at 2**CW-1 (it never wraps).
- Comparison is unsigned, full W bits.
- Read: rd_en in RUN at cycle N gives rd_data = mem[rd_addr] and rd_valid=1 at cycle N+1 (latency 1). Otherwise rd_valid=0 and rd_data holds its last value.
- Collision (same addr, accepted write, same cycle): WR_FIRST=0 returns the old word; WR_FIRST=1 returns wr_data. A rejected write never bypasses.
- Reset mid-operation: returns to INIT immediately. The sweep re-clears all words, and the counter is cleared.
- Assertion A1: when ready, mem[rd_addr] < THRESH (combinational, over the whole array via free rd_addr).
- Assertion A2: rd_valid implies rd_data < THRESH.
- Assertion A3: ready implies state==RUN.
- Assertions are compiled under the formal define; all must be provable by k-induction with the sweep ptr as a strengthening invariant.
- States: INIT, RUN only; no other encoding is reachable.

Decomposition:
- Package bounded_mem_pkg holds:
  - state enum {INIT, RUN}
  - function in_bound(data, thresh) returning data < thresh
  - localparam helper for DEPTH
- Sub-module mem_1r1w (W, AW, WR_FIRST) holds the raw array, the registered read, and collision muxing.
- The top holds the FSM, sweep ptr, filter, counter and assertions.

Test Plan (W=8, AW=4, THRESH=200, CW=4):
- Release rst_n, then immediately pulse wr_en with addr 3, data 5 -> ignored; ready rises after 16 cycles; reading addr 3 returns 0 with rd_valid one cycle later.
- RUN: write addr 2 data 199, then read addr 2 -> rd_data=199, rd_valid=1 exactly one cycle after rd_en.
- Write addr 2 data 200, then data 255 -> mem[2] stays 199; reject_cnt=2.
- Issue 20 rejected writes -> reject_cnt saturates at 15, no wrap.
- Same-cycle write of 7 and read of addr 4 (old value 9): WR_FIRST=0 gives rd_data=9; WR_FIRST=1 gives rd_data=7. A same-cycle rejected write of 250 gives 9 in both modes.
- Assert rst_n low mid-traffic -> ready, rd_valid and reject_cnt go to 0 at once. After re-sweep, all 16 addresses read 0. No assertion fires at any point.

Source files
------------

// File: rtl/bounded_mem_pkg.sv
// Shared types and helpers for the threshold-filtered 1R1W memory.
// The bound check is done at a fixed 64-bit width so one function serves every W.
package bounded_mem_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic logic in_bound(input logic [MAX_W-1:0] data,
                                    input logic [MAX_W-1:0] thresh);
    return data < thresh;
  endfunction

endpackage

// File: rtl/mem_1r1w.sv
// Raw 1-write/1-read array with a registered read port and a configurable
// same-address collision policy (read-first or write-first bypass).
module mem_1r1w
  import bounded_mem_pkg::*;
#(
  parameter int W        = 32,
  parameter int AW       = 8,
  parameter int WR_FIRST = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata,
  output logic          rvalid
);

  localparam int unsigned DEPTH = depth_of(AW);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; it is cleared by the owner's init sweep,
  // which keeps it mappable onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  logic bypass;
  assign bypass = (WR_FIRST != 0) && we && (waddr == raddr);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= bypass ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/bounded_mem_1r1w.sv
// 1W/1R memory that only stores words strictly below THRESH, cleared by a
// post-reset sweep and counting rejected writes with a saturating counter.
module bounded_mem_1r1w
  import bounded_mem_pkg::*;
#(
  parameter int              W        = 32,
  parameter int              AW       = 8,
  parameter longint unsigned THRESH   = 200,
  parameter int              CW       = 16,
  parameter int              WR_FIRST = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          ready,
  output logic [CW-1:0] reject_cnt
);

  localparam int unsigned DEPTH = depth_of(AW);

  if (W < 1 || W > MAX_W) begin : g_bad_width
    $error("bounded_mem_1r1w: W must be in 1..64");
  end
  if (THRESH == 0 || (W < MAX_W && (THRESH >> W) != 0)) begin : g_bad_thresh
    $error("bounded_mem_1r1w: THRESH must be in 1..2**W-1");
  end

  state_e        state;
  logic [AW-1:0] ptr;
  logic          wr_ok;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;
  logic          mem_re;

  assign wr_ok = in_bound(MAX_W'(wr_data), THRESH);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    mem_re    = 1'b0;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = ptr;
      mem_wdata = '0;
    end else begin
      mem_we = wr_en && wr_ok;
      mem_re = rd_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      ptr        <= '0;
      ready      <= 1'b0;
      reject_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == AW'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (wr_en && !wr_ok && reject_cnt != '1) reject_cnt <= reject_cnt + 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  mem_1r1w #(
    .W        (W),
    .AW       (AW),
    .WR_FIRST (WR_FIRST)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wdata  (mem_wdata),
    .re     (mem_re),
    .raddr  (rd_addr),
    .rdata  (rd_data),
    .rvalid (rd_valid)
  );

`ifdef FORMAL
  // rd_addr is free, so the per-address properties cover the whole array.
  always_comb begin
    if (rst_n) begin
      a1_mem_bound:  assert (!ready || in_bound(MAX_W'(u_mem.mem[rd_addr]), THRESH));
      a2_rd_bound:   assert (!rd_valid || in_bound(MAX_W'(rd_data), THRESH));
      a3_ready_run:  assert (!ready || state == RUN);
      // Induction strengthening: swept words are clean, ready tracks RUN.
      s1_run_ready:  assert (state != RUN || ready);
      s2_valid_run:  assert (!rd_valid || state == RUN);
      s3_swept_zero: assert (!(state == INIT && rd_addr < ptr)
                             || in_bound(MAX_W'(u_mem.mem[rd_addr]), THRESH));
      s4_ptr_run:    assert (state != RUN || ptr == '0);
    end
  end
`endif

endmodule

// File: tb/tb_bounded_mem_1r1w.sv
// Directed bench for bounded_mem_1r1w in both collision modes; reads push
// expectations into a scoreboard that a negedge monitor drains.
module tb_bounded_mem_1r1w;

  localparam int              W  = 8;
  localparam int              AW = 4;
  localparam int              CW = 4;
  localparam longint unsigned TH = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [W-1:0]  rd_data_rf, rd_data_wf;
  logic          rd_valid_rf, rd_valid_wf;
  logic          ready_rf, ready_wf;
  logic [CW-1:0] cnt_rf, cnt_wf;

  bounded_mem_1r1w #(.W(W), .AW(AW), .THRESH(TH), .CW(CW), .WR_FIRST(0)) u_rf (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_rf), .rd_valid(rd_valid_rf),
    .ready(ready_rf), .reject_cnt(cnt_rf)
  );

  bounded_mem_1r1w #(.W(W), .AW(AW), .THRESH(TH), .CW(CW), .WR_FIRST(1)) u_wf (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_wf), .rd_valid(rd_valid_wf),
    .ready(ready_wf), .reject_cnt(cnt_wf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] d_rf;
    logic [W-1:0] d_wf;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rd_valid_rf || rd_valid_wf) begin
      check("rd_valid_modes_agree", 32'(rd_valid_wf), 32'(rd_valid_rf));
      if (sb.size() == 0) begin
        check("spurious_rd_valid", 32'(rd_valid_rf | rd_valid_wf), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rd_latency", cyc, e.cyc + 1);
        check("rd_data_read_first", 32'(rd_data_rf), 32'(e.d_rf));
        check("rd_data_write_first", 32'(rd_data_wf), 32'(e.d_wf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] e_rf, input logic [W-1:0] e_wf);
    rd_en   = 1'b1;
    rd_addr = a;
    sb.push_back('{e_rf, e_wf, cyc});
    step();
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_cnt(input string name, input logic [CW-1:0] req);
    check(name, {cnt_rf, cnt_wf}, {req, req});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {ready_rf, ready_wf}, 2'b00);
    check("reset_rd_valid", {rd_valid_rf, rd_valid_wf}, 2'b00);
    check("reset_rd_data", {rd_data_rf, rd_data_wf}, 16'd0);
    check_cnt("reset_reject_cnt", 4'd0);

    // Requests during the sweep must be ignored entirely.
    rst_n   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_data = 8'd5;
    rd_en   = 1'b1;
    rd_addr = 4'd3;
    step();
    wr_addr = 4'd5;
    wr_data = 8'd250;
    rd_en   = 1'b0;
    step();
    wr_en = 1'b0;
    repeat (13) step();
    check("init_not_ready_at_15", {ready_rf, ready_wf}, 2'b00);
    step();
    check("ready_at_16", {ready_rf, ready_wf}, 2'b11);
    check_cnt("init_no_count", 4'd0);
    rd(4'd3, 8'd0, 8'd0);

    wr(4'd2, 8'd199);
    rd(4'd2, 8'd199, 8'd199);

    wr(4'd2, 8'd200);
    wr(4'd2, 8'd255);
    check_cnt("reject_cnt_2", 4'd2);
    rd(4'd2, 8'd199, 8'd199);

    wr_en   = 1'b1;
    wr_addr = 4'd2;
    wr_data = 8'd230;
    repeat (12) step();
    check_cnt("reject_cnt_14", 4'd14);
    repeat (8) step();
    wr_en = 1'b0;
    check_cnt("reject_cnt_saturated", 4'd15);

    // Accepted collision: old word vs bypassed write data.
    wr(4'd4, 8'd9);
    wr_en   = 1'b1;
    wr_addr = 4'd4;
    wr_data = 8'd7;
    rd(4'd4, 8'd9, 8'd7);
    wr_en = 1'b0;
    rd(4'd4, 8'd7, 8'd7);

    // Rejected collision: never bypasses.
    wr(4'd4, 8'd9);
    wr_en   = 1'b1;
    wr_addr = 4'd4;
    wr_data = 8'd250;
    rd(4'd4, 8'd9, 8'd9);
    wr_en = 1'b0;
    rd(4'd4, 8'd9, 8'd9);
    check_cnt("reject_cnt_still_15", 4'd15);

    // Reset asserted while a read result is on the port.
    wr_en   = 1'b1;
    wr_addr = 4'd6;
    wr_data = 8'd100;
    rd(4'd2, 8'd199, 8'd199);
    wr_data = 8'd240;
    check("valid_before_rst", {rd_valid_rf, rd_valid_wf}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("rst_ready", {ready_rf, ready_wf}, 2'b00);
    check("rst_rd_valid", {rd_valid_rf, rd_valid_wf}, 2'b00);
    check_cnt("rst_reject_cnt", 4'd0);
    wr_en = 1'b0;

    step();
    rst_n = 1'b1;
    repeat (15) step();
    check("resweep_not_ready", {ready_rf, ready_wf}, 2'b00);
    step();
    check("resweep_ready", {ready_rf, ready_wf}, 2'b11);
    check_cnt("resweep_cnt", 4'd0);
    for (int a = 0; a < 16; a++) rd(AW'(a), 8'd0, 8'd0);

    repeat (4) step();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
